// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding and default widths for the convolution engine.
// The derived accumulator width is sized so a full-length MAC never overflows.
package conv_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_MAX_SIZE   = 5;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        MAC,
        WRITE,
        DONE
    } state_t;

    function automatic int acc_width(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered multiply-accumulate plus the out() reduction to memZ width.
// CONV_SAT_EN defined: results above the output range saturate; undefined: low bits kept.
module conv_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [OUT_WIDTH-1:0]  out_data
);
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_d;
    logic [ACC_WIDTH-1:0]    acc_q;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef CONV_SAT_EN
    localparam logic [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({OUT_WIDTH{1'b1}});

    always_comb begin
        if (acc_q > OUT_MAX) begin
            out_data = '1;
        end else begin
            out_data = OUT_WIDTH'(acc_q);
        end
    end
`else
    assign out_data = OUT_WIDTH'(acc_q);
`endif
endmodule

// File: rtl/conv_core.sv
// conv_core: sequential linear convolution Z = X * Y between memX/memY and memZ.
// Output reduction (saturate vs. truncate) is chosen by CONV_SAT_EN inside conv_mac.
module conv_core
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_SIZE   = DEF_MAX_SIZE,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] sizeX,
    input  logic [ADDR_WIDTH-1:0] sizeY,
    output logic [ADDR_WIDTH-1:0] memX_addr,
    output logic                  memX_rd,
    input  logic [DATA_WIDTH-1:0] dataX,
    output logic [ADDR_WIDTH-1:0] memY_addr,
    output logic                  memY_rd,
    input  logic [DATA_WIDTH-1:0] dataY,
    output logic [ADDR_WIDTH:0]   memZ_addr,
    output logic [OUT_WIDTH-1:0]  memZ_data,
    output logic                  memZ_wr,
    output logic                  busy,
    output logic                  done
);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ADDR_WIDTH);
    localparam int NW        = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] size_x_q, size_x_d, size_y_q, size_y_d;
    logic [NW-1:0]         n_q, n_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d, kmax_q, kmax_d;
    logic [NW-1:0]         n_last, kmin_w, kmax_w;
    logic [ADDR_WIDTH-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d;
    logic [NW-1:0]         z_addr_q, z_addr_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic                  busy_q, busy_d, done_q, done_d;

    function automatic logic [ADDR_WIDTH-1:0] clamp_size(input logic [ADDR_WIDTH-1:0] s);
        return (int'(s) > MAX_SIZE) ? ADDR_WIDTH'(MAX_SIZE) : s;
    endfunction

    // Valid k range for output n: X index inside [0,sizeX), Y index n-k inside [0,sizeY).
    assign n_last = {1'b0, size_x_q} + {1'b0, size_y_q} - NW'(2);
    assign kmin_w = (n_q >= {1'b0, size_y_q}) ? (n_q - {1'b0, size_y_q} + NW'(1)) : '0;
    assign kmax_w = (n_q < ({1'b0, size_x_q} - NW'(1))) ? n_q : ({1'b0, size_x_q} - NW'(1));

    always_comb begin
        state_d  = state_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        n_d      = n_q;
        k_d      = k_q;
        kmax_d   = kmax_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    size_x_d = clamp_size(sizeX);
                    size_y_d = clamp_size(sizeY);
                    n_d      = '0;
                    state_d  = (size_x_d == '0 || size_y_d == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                k_d     = ADDR_WIDTH'(kmin_w);
                kmax_d  = ADDR_WIDTH'(kmax_w);
                state_d = READ;
            end
            READ: state_d = MAC;
            MAC: begin
                if (k_q == kmax_q) begin
                    state_d = WRITE;
                end else begin
                    k_d     = k_q + ADDR_WIDTH'(1);
                    state_d = READ;
                end
            end
            WRITE: begin
                if (n_q == n_last) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + NW'(1);
                    state_d = CLEAR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are computed from the next state so they are registered yet valid in-state.
        rd_d     = (state_d == READ);
        x_addr_d = rd_d ? k_d : '0;
        y_addr_d = rd_d ? ADDR_WIDTH'(n_d - NW'(k_d)) : '0;
        wr_d     = (state_d == WRITE);
        z_addr_d = wr_d ? n_d : '0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            size_x_q <= '0;
            size_y_q <= '0;
            n_q      <= '0;
            k_q      <= '0;
            kmax_q   <= '0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            z_addr_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            n_q      <= n_d;
            k_q      <= k_d;
            kmax_q   <= kmax_d;
            x_addr_q <= x_addr_d;
            y_addr_q <= y_addr_d;
            z_addr_q <= z_addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    conv_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == CLEAR),
        .acc_en  (state_q == MAC),
        .a       (dataX),
        .b       (dataY),
        .out_data(memZ_data)
    );

    assign memX_addr = x_addr_q;
    assign memY_addr = y_addr_q;
    assign memX_rd   = rd_q;
    assign memY_rd   = rd_q;
    assign memZ_addr = z_addr_q;
    assign memZ_wr   = wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_conv_core.sv
// tb_conv_core: table vectors, hand-written corner sequences and randomized runs for conv_core.
// Expected results come from hand constants or a direct sum-of-products reference model.
`timescale 1ns/1ps
module tb_conv_core;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int MS = 5;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] sizeX = '0;
    logic [AW-1:0] sizeY = '0;
    logic [AW-1:0] memX_addr, memY_addr;
    logic          memX_rd, memY_rd;
    logic [DW-1:0] dataX = '0;
    logic [DW-1:0] dataY = '0;
    logic [AW:0]   memZ_addr;
    logic [OW-1:0] memZ_data;
    logic          memZ_wr, busy, done;

    conv_core #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_SIZE  (MS),
        .OUT_WIDTH (OW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sizeX    (sizeX),
        .sizeY    (sizeY),
        .memX_addr(memX_addr),
        .memX_rd  (memX_rd),
        .dataX    (dataX),
        .memY_addr(memY_addr),
        .memY_rd  (memY_rd),
        .dataY    (dataY),
        .memZ_addr(memZ_addr),
        .memZ_data(memZ_data),
        .memZ_wr  (memZ_wr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Sample memories with one-cycle synchronous read.
    logic [DW-1:0] memx [0:7];
    logic [DW-1:0] memy [0:7];
    always @(posedge clk) begin
        if (memX_rd) dataX <= memx[memX_addr];
        if (memY_rd) dataY <= memy[memY_addr];
    end

    // Observed traffic, sampled mid-cycle.
    int wz_addr [$];
    int wz_data [$];
    int rd_x [$];
    int rd_y [$];
    int done_cnt = 0;
    int rd_skew = 0;
    always @(negedge clk) begin
        if (memZ_wr) begin
            wz_addr.push_back(int'(memZ_addr));
            wz_data.push_back(int'(memZ_data));
        end
        if (memX_rd) begin
            rd_x.push_back(int'(memX_addr));
            rd_y.push_back(int'(memY_addr));
        end
        if (memX_rd !== memY_rd) rd_skew++;
        if (done) done_cnt++;
    end

    int total = 0;
    int bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: plain sum of products over the effective (clamped) lengths.
    function automatic int eff(input int s);
        return (s > MS) ? MS : s;
    endfunction

    function automatic int ref_out(input longint s);
`ifdef CONV_SAT_EN
        return (s > 65535) ? 65535 : int'(s);
`else
        return int'(s % 65536);
`endif
    endfunction

    function automatic longint ref_sum(input int n, input int ex, input int ey);
        longint s;
        s = 0;
        for (int k = 0; k < ex; k++)
            if (n - k >= 0 && n - k < ey) s += longint'(memx[k]) * longint'(memy[n-k]);
        return s;
    endfunction

    function automatic int ref_cycles(input int ex, input int ey);
        int c;
        int t;
        if (ex == 0 || ey == 0) return 1;
        c = 1;
        for (int n = 0; n <= ex + ey - 2; n++) begin
            t = 0;
            for (int k = 0; k < ex; k++)
                if (n - k >= 0 && n - k < ey) t++;
            c += 2 + 2 * t;
        end
        return c;
    endfunction

    typedef struct packed {
        logic [2:0]   sx;
        logic [2:0]   sy;
        logic [39:0]  xv;
        logic [39:0]  yv;
        logic [3:0]   nw;
        logic [7:0]   cyc;
        logic [143:0] zv;
    } vec_t;

    vec_t tv [6];
    int   exp_z [$];
    int   run_cyc;
    int   base_w;
    int   base_r;
    int   base_d;

    // Unused memory slots hold a marker so out-of-range reads corrupt the result.
    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            memx[i] = (i < 5 && i < eff(int'(v.sx))) ? v.xv[8*i +: 8] : 8'd100;
            memy[i] = (i < 5 && i < eff(int'(v.sy))) ? v.yv[8*i +: 8] : 8'd100;
        end
    endtask

    task automatic do_run(input logic [AW-1:0] sx, input logic [AW-1:0] sy, input bit inject);
        int cyc;
        bit got;
        @(negedge clk);
        sizeX = sx;
        sizeY = sy;
        start = 1'b1;
        base_w = wz_addr.size();
        base_r = rd_x.size();
        base_d = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        sizeX = AW'($urandom);
        sizeY = AW'($urandom);
        chk("busy_after_start", busy, 1);
        cyc = 0;
        got = 0;
        while (!got && cyc < 400) begin
            cyc++;
            if (done) begin
                got = 1;
            end else begin
                start = (inject && cyc == 7);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        run_cyc = got ? cyc : -1;
        @(posedge clk);
        #1;
        chk("done_pulse_width", done, 0);
        chk("idle_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt - base_d, 1);
    endtask

    task automatic check_run(input string nm, input int ex, input int ey, input int exp_cyc);
        int nw;
        int rbad;
        int idx;
        nw = wz_addr.size() - base_w;
        chk({nm, ":cycles"}, run_cyc, exp_cyc);
        chk({nm, ":nwrites"}, nw, exp_z.size());
        for (int i = 0; i < nw && i < exp_z.size(); i++) begin
            chk($sformatf("%s:z%0d_addr", nm, i), wz_addr[base_w+i], i);
            chk($sformatf("%s:z%0d_data", nm, i), wz_data[base_w+i], exp_z[i]);
        end
        rbad = 0;
        idx = base_r;
        if (ex > 0 && ey > 0) begin
            for (int n = 0; n <= ex + ey - 2; n++)
                for (int k = 0; k < ex; k++)
                    if (n - k >= 0 && n - k < ey) begin
                        if (idx >= rd_x.size() || rd_x[idx] != k || rd_y[idx] != n - k) rbad++;
                        idx++;
                    end
        end
        if (idx != rd_x.size()) rbad++;
        chk({nm, ":read_order"}, rbad, 0);
        $display("run %s sx=%0d sy=%0d writes=%0d cycles=%0d", nm, ex, ey, nw, run_cyc);
    endtask

    int rsx, rsy, rex, rey, wait_cyc;

    initial begin
        tv[0] = '{sx: 3'd3, sy: 3'd2, xv: {16'd0, 8'd3, 8'd2, 8'd1}, yv: {24'd0, 8'd1, 8'd1},
                  nw: 4'd4, cyc: 8'd21, zv: {80'd0, 16'd3, 16'd5, 16'd3, 16'd1}};
        tv[1] = '{sx: 3'd0, sy: 3'd3, xv: 40'd0, yv: {16'd0, 8'd3, 8'd2, 8'd1},
                  nw: 4'd0, cyc: 8'd1, zv: 144'd0};
        tv[2] = '{sx: 3'd1, sy: 3'd1, xv: {32'd0, 8'd7}, yv: {32'd0, 8'd9},
                  nw: 4'd1, cyc: 8'd5, zv: {128'd0, 16'd63}};
`ifdef CONV_SAT_EN
        tv[3] = '{sx: 3'd5, sy: 3'd5, xv: {5{8'd255}}, yv: {5{8'd255}},
                  nw: 4'd9, cyc: 8'd69, zv: {16'hFE01, {7{16'hFFFF}}, 16'hFE01}};
`else
        tv[3] = '{sx: 3'd5, sy: 3'd5, xv: {5{8'd255}}, yv: {5{8'd255}},
                  nw: 4'd9, cyc: 8'd69,
                  zv: {16'hFE01, 16'hFC02, 16'hFA03, 16'hF804, 16'hF605,
                       16'hF804, 16'hFA03, 16'hFC02, 16'hFE01}};
`endif
        tv[4] = '{sx: 3'd7, sy: 3'd2, xv: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, yv: {24'd0, 8'd1, 8'd1},
                  nw: 4'd6, cyc: 8'd33, zv: {48'd0, 16'd5, 16'd9, 16'd7, 16'd5, 16'd3, 16'd1}};
        tv[5] = '{sx: 3'd4, sy: 3'd0, xv: {8'd0, 8'd4, 8'd3, 8'd2, 8'd1}, yv: 40'd0,
                  nw: 4'd0, cyc: 8'd1, zv: 144'd0};

        for (int i = 0; i < 8; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end

        #12;
        chk("reset_outputs", {memX_addr, memX_rd, memY_addr, memY_rd, memZ_addr,
                              memZ_data, memZ_wr, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            load(tv[i]);
            exp_z.delete();
            for (int j = 0; j < int'(tv[i].nw); j++) exp_z.push_back(int'(tv[i].zv[16*j +: 16]));
            do_run(tv[i].sx, tv[i].sy, 1'b0);
            check_run($sformatf("vec%0d", i), eff(int'(tv[i].sx)), eff(int'(tv[i].sy)),
                      int'(tv[i].cyc));
        end

        // start pulsed while the basic run is in MAC: must be ignored.
        load(tv[0]);
        exp_z.delete();
        for (int j = 0; j < 4; j++) exp_z.push_back(int'(tv[0].zv[16*j +: 16]));
        do_run(3'd3, 3'd2, 1'b1);
        check_run("start_busy", 3, 2, 21);

        // Reset asserted during the first READ of n=2.
        @(negedge clk);
        sizeX = 3'd3;
        sizeY = 3'd2;
        start = 1'b1;
        base_w = wz_addr.size();
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc = 0;
        while (!((wz_addr.size() - base_w) == 2 && memX_rd) && wait_cyc < 100) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        chk("reset_reached_read_n2", wait_cyc < 100, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_midrun_outputs", {memX_addr, memX_rd, memY_addr, memY_rd, memZ_addr,
                                     memZ_data, memZ_wr, busy, done}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_writes_after_reset", wz_addr.size() - base_w, 2);
        chk("pre_reset_z1", wz_data[base_w+1], 3);
        do_run(3'd3, 3'd2, 1'b0);
        check_run("after_reset", 3, 2, 21);

        // Randomized runs against the reference model.
        for (int r = 0; r < 24; r++) begin
            rsx = $urandom_range(0, 7);
            rsy = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                memx[i] = (r % 3 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
                memy[i] = (r % 3 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
            end
            rex = eff(rsx);
            rey = eff(rsy);
            exp_z.delete();
            if (rex > 0 && rey > 0)
                for (int n = 0; n <= rex + rey - 2; n++) exp_z.push_back(ref_out(ref_sum(n, rex, rey)));
            do_run(AW'(rsx), AW'(rsy), (r % 4) == 1);
            check_run($sformatf("rand%0d", r), rex, rey, ref_cycles(rex, rey));
        end

        chk("rd_strobes_paired", rd_skew, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_core.md
# conv_core

Convolution engine that sits directly downstream of the memX and memY sample memories and upstream of memZ. On `start`, it reads operand vectors X and Y through their synchronous read ports. It computes the discrete linear convolution Z[n] = Σ X[k]·Y[n−k] and writes each Z[n] to memZ in ascending address order. It is the only consumer of memY's read port during a run.

## Interface
Parameters:
- `DATA_WIDTH`, 8: operand width; X and Y are unsigned.
- `ADDR_WIDTH`, 3: memX/memY address width.
- `MAX_SIZE`, 5: memory depth; this is the largest legal vector length.
- `OUT_WIDTH`, 16: memZ data width.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: begin a run; sampled only in IDLE.
- `sizeX`, input, ADDR_WIDTH: X length; latched at start.
- `sizeY`, input, ADDR_WIDTH: Y length; latched at start.
- `memX_addr`, output, ADDR_WIDTH: X read address.
- `memX_rd`, output, 1: X readEnable.
- `dataX`, input, DATA_WIDTH: memX readData, valid the cycle after `memX_rd`.
- `memY_addr`, output, ADDR_WIDTH: Y read address.
- `memY_rd`, output, 1: Y readEnable.
- `dataY`, input, DATA_WIDTH: memY readData, valid the cycle after `memY_rd`.
- `memZ_addr`, output, ADDR_WIDTH+1: Z write address.
- `memZ_data`, output, OUT_WIDTH: Z write data.
- `memZ_wr`, output, 1: Z writeEnable, a 1-cycle pulse.
- `busy`, output, 1: high from the cycle after start is accepted until DONE inclusive.
- `done`, output, 1: 1-cycle pulse at the end of a run.

## Operation
- FSM states: IDLE, CLEAR, READ, MAC, WRITE, DONE.
- **IDLE:** `start`=1 latches sizes, sets n=0, and goes to CLEAR. Sizes greater than MAX_SIZE are clamped to MAX_SIZE.
- **Empty run:** if either latched size is 0, go directly to DONE; no memZ writes occur.
- **CLEAR:** acc=0, kmin=max(0, n−sizeY+1), kmax=min(n, sizeX−1), k=kmin. Then go to READ.
- **READ:** `memX_rd`=`memY_rd`=1, `memX_addr`=k, `memY_addr`=n−k. Then go to MAC.
- **MAC:** acc += dataX·dataY. If k==kmax go to WRITE; otherwise k++ and go to READ.
- **WRITE:** `memZ_wr`=1, `memZ_addr`=n, `memZ_data`=out(acc).
  - If n==sizeX+sizeY−2, go to DONE.
  - Otherwise n++ and go to CLEAR.
- **DONE:** `done`=1, then go to IDLE.
- **Arithmetic:**
  - Product width is 2·DATA_WIDTH.
  - acc width is 2·DATA_WIDTH+ADDR_WIDTH, so acc never overflows.
  - out() reduces acc to OUT_WIDTH (see Configuration).
- **Busy/start rules:**
  - `start` while busy is ignored; it is neither queued nor a restart.
  - `sizeX`/`sizeY` changes after acceptance have no effect on the run.
- **Reset:** asserting `rst_n` mid-run aborts immediately, returns the FSM to IDLE, and clears all outputs. memZ keeps any results already written.

## Timing
- **Reset values:** every output is 0, state is IDLE, and acc=0.
- **Outputs are registered:** read/write strobes are asserted during their state cycle.
- **Read latency:** 1 cycle. The address is issued in READ and the data is consumed in MAC.
- **Per output Z[n]:** 2 + 2·T(n) cycles, where T(n)=kmax−kmin+1.
- **Total run:** Σ(2+2·T(n)) + 1 (DONE) cycles from the start-accepting edge to `done`. An empty run takes 1 cycle.
- **Next run:** `start` may be accepted on the first IDLE cycle after DONE.

## Configuration
- Macro: `CONV_SAT_EN`.
- **Defined:** out() saturates, so acc > 2^OUT_WIDTH−1 gives all-ones.
- **Undefined:** out() keeps the low OUT_WIDTH bits (modulo truncation).
- No other behaviour differs.

## Structure
- **Package `conv_pkg`:**
  - `state_t` enum: IDLE, CLEAR, READ, MAC, WRITE, DONE.
  - Default constants: DATA_WIDTH, ADDR_WIDTH, MAX_SIZE, OUT_WIDTH.
  - Derived acc width constant.
- **Sub-module `conv_mac`:** registered accumulator with clear and accumulate inputs, plus the out() reduction. The `CONV_SAT_EN` selection lives in `conv_mac` only.

## Test plan
- **Basic run:**
  - Stimulus: X={1,2,3}, Y={1,1}.
  - Response: memZ writes addr 0..3 = {1,3,5,3}. `done` arrives 21 cycles after the start edge (20 + 1). The Y addresses per term follow n−k.
- **Saturation, `CONV_SAT_EN` defined:**
  - Stimulus: X=Y={255,255,255,255,255}.
  - Response: Z[0]=Z[8]=0xFE01; Z[1..7]=0xFFFF; 9 writes total.
- **Truncation, `CONV_SAT_EN` undefined:**
  - Stimulus: same vectors.
  - Response: Z[0]=0xFE01; Z[4]=0xF605 (325125 mod 65536).
- **Boundary sizes:**
  - sizeX=0 with sizeY=3: no `memZ_wr`; `done` 1 cycle after start.
  - sizeX=7: clamped to 5.
  - sizeX=sizeY=1, X={7}, Y={9}: one write, Z[0]=63.
- **Start while busy:**
  - Stimulus: pulse `start` during MAC of a run.
  - Response: no restart, identical results, exactly one `done`.
- **Reset mid-run:**
  - Stimulus: assert `rst_n`=0 during the READ of n=2.
  - Response:
    - All outputs are 0 in the same cycle.
    - No further writes occur.
    - A new start gives a full, correct run.
